room_tile_drawer: RTL and testbench
===================================

# room_tile_drawer

VGA drawing engine directly downstream of the home-simulation control FSM. On a one-cycle `drawen` request it latches a room number and that room's function/state bits. It then streams one pixel per clock (`x`, `y`, `colour`, `plot`) to the VGA adapter to paint the room's status tile, or on `clearinitsignal` it blanks the full screen. It returns a one-cycle `countDone` pulse, which the control FSM waits on in its ROOMn/CLEAR states.

## Interface
- `TILE_W`, default 8: tile width in pixels, 2..16.
- `TILE_H`, default 8: tile height in pixels, 2..16.
- `SCREEN_W`, default 160: clear-sweep width.
- `SCREEN_H`, default 120: clear-sweep height.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `drawen`  in  1  start tile draw; sampled only in IDLE.
- `clearinitsignal`  in  1  start full-screen clear; sampled only in IDLE.
- `roomno`  in  4  room index 0..9; latched with `drawen`.
- `funct`  in  1  1 = LIGHT, 0 = DOOR; latched with `drawen`.
- `onoff`  in  1  1 = ON/open, 0 = OFF/closed; latched with `drawen`.
- `x`  out  8  pixel column, registered.
- `y`  out  7  pixel row, registered.
- `colour`  out  3  RGB pixel colour, registered.
- `plot`  out  1  pixel write strobe, registered.
- `busy`  out  1  high in DRAW, CLEAR and DONE.
- `countDone`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, DRAW, CLEAR, DONE.
- IDLE -> CLEAR when `clearinitsignal`=1. Clear wins if `drawen` is also 1 in the same cycle.
- IDLE -> DRAW when `drawen`=1 and `roomno`<=9. Latch `roomno`, `funct` and `onoff`; zero the pixel counters `cx` and `cy`.
- IDLE -> DONE when `drawen`=1 and `roomno`>9. No pixels are plotted.
- Room origin: `ox` = (`roomno` mod 5)*32 + 12, `oy` = (`roomno` div 5)*60 + 26. Rooms form a 5x2 grid.
- DRAW: each cycle emit `x`=`ox`+`cx`, `y`=`oy`+`cy`, `plot`=1.
  - `cx` increments and wraps at `TILE_W`-1. `cy` increments on each `cx` wrap.
  - After pixel (`TILE_W`-1, `TILE_H`-1) the block goes to DONE.
- Fill colour:
  - LIGHT ON = 3'b110 (yellow).
  - LIGHT OFF = 3'b001 (blue).
  - DOOR open = 3'b010 (green).
  - DOOR closed = 3'b100 (red).
- CLEAR: same raster over `SCREEN_W`x`SCREEN_H` from (0,0), `colour`=3'b000, `plot`=1. After pixel (159,119) the block goes to DONE.
- DONE: `countDone`=1 for exactly one cycle, then IDLE.
- `drawen` and `clearinitsignal` are ignored outside IDLE; there is no queueing.
- Input changes after the start cycle do not affect the tile in progress.
- Address arithmetic: unsigned, 8-bit x / 7-bit y. No wrap occurs for legal parameter values.

## Timing
- Reset values: `x`=0, `y`=0, `colour`=0, `plot`=0, `busy`=0, `countDone`=0; state=IDLE; counters 0.
- Start sampled at edge N. The first pixel is valid on the outputs after edge N+1.
- A tile draw asserts `plot` for exactly `TILE_W`*`TILE_H` consecutive cycles (64 by default).
- `countDone` is high the cycle after the last plotted pixel; `plot` is 0 in that cycle.
- Start-to-`countDone` latency: draw = `TILE_W`*`TILE_H`+1 cycles; clear = 19201 cycles; invalid room = 1 cycle.
- The earliest next start is accepted on the cycle after `countDone`.
- `reset` mid-operation aborts at the next edge: `plot` drops to 0 and no `countDone` is issued.

## Configuration
- `ROOM_BORDER_EN` defined: in DRAW, pixels with `cx`=0, `cx`=`TILE_W`-1, `cy`=0 or `cy`=`TILE_H`-1 are drawn 3'b111 (white); interior pixels use the fill colour.
- `ROOM_BORDER_EN` undefined: all tile pixels use the fill colour.
- Pixel count and timing are identical in both builds.

## Test plan
- Reset, then `drawen` with `roomno`=0, `funct`=1, `onoff`=1 -> 64 plots covering x 12..19, y 26..33, all colour 3'b110; `countDone` exactly 65 cycles after start.
- `roomno`=7, `funct`=0, `onoff`=0 -> origin (76,86); first pixel (76,86), last (83,93), colour 3'b100. With `ROOM_BORDER_EN`: 28 white border pixels and 36 red interior pixels.
- `clearinitsignal` and `drawen` asserted in the same cycle -> clear runs: 19200 black plots ending at (159,119), then `countDone`.
- `roomno`=12 with `drawen` -> zero plots, `countDone` on the next cycle.
- Pulse `drawen` again mid-draw of room 3 (`funct`=0, `onoff`=1) -> ignored; a single 64-pixel green tile and a single `countDone`.
- `reset` at pixel 20 of a draw -> `plot`=0 next cycle, no `countDone`; a new `drawen` then completes normally.

Source files
------------

// File: rtl/room_tile_drawer_if.sv
// room_tile_drawer_if
// Handshake and pixel bus between the home-simulation control FSM (master)
// and the room tile drawer (slave).
//   drawen          master->slave  one-cycle request to draw a room tile
//   clearinitsignal master->slave  one-cycle request to blank the screen
//   roomno[3:0]     master->slave  room index, latched with drawen
//   funct           master->slave  1 = LIGHT, 0 = DOOR
//   onoff           master->slave  1 = ON/open, 0 = OFF/closed
//   x[7:0], y[6:0]  slave->master  pixel coordinate for the VGA adapter
//   colour[2:0]     slave->master  RGB pixel colour
//   plot            slave->master  pixel write strobe
//   busy            slave->master  drawer is not idle
//   countDone       slave->master  one-cycle completion pulse
interface room_tile_drawer_if;
  logic       drawen;
  logic       clearinitsignal;
  logic [3:0] roomno;
  logic       funct;
  logic       onoff;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       countDone;

  modport master (
    output drawen, clearinitsignal, roomno, funct, onoff,
    input  x, y, colour, plot, busy, countDone
  );

  modport slave (
    input  drawen, clearinitsignal, roomno, funct, onoff,
    output x, y, colour, plot, busy, countDone
  );
endinterface

// File: rtl/room_tile_drawer.sv
// room_tile_drawer
// Streams one pixel per clock to a VGA adapter: either a TILE_W x TILE_H
// status tile for one of ten rooms (5x2 grid), or a full-screen black clear.
// Finishes with a one-cycle countDone pulse.
// Ports:
//   clock  rising-edge system clock
//   reset  synchronous active-high reset
//   bus    room_tile_drawer_if.slave (request inputs, registered pixel outputs)
// Build option: define ROOM_BORDER_EN to draw the tile outline in white.
module room_tile_drawer #(
  parameter int TILE_W   = 8,
  parameter int TILE_H   = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input logic           clock,
  input logic           reset,
  room_tile_drawer_if.slave bus
);

  localparam logic [7:0] TW_LAST = 8'(TILE_W - 1);
  localparam logic [6:0] TH_LAST = 7'(TILE_H - 1);
  localparam logic [7:0] SW_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] SH_LAST = 7'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, DRAW, CLEAR, DONE} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_cx, w_cx_nxt;
  logic [6:0] r_cy, w_cy_nxt;
  logic [3:0] r_room, w_room_nxt;
  logic       r_funct, w_funct_nxt;
  logic       r_onoff, w_onoff_nxt;
  logic [7:0] r_x, w_x_nxt;
  logic [6:0] r_y, w_y_nxt;
  logic [2:0] r_colour, w_colour_nxt;
  logic       r_plot, w_plot_nxt;
  logic       r_done, w_done_nxt;

  logic [2:0] w_col;
  logic [7:0] w_ox;
  logic [6:0] w_oy;

  function automatic logic [2:0] fill_colour(input logic f, input logic o);
    if (f) return o ? 3'b110 : 3'b001;
    else   return o ? 3'b010 : 3'b100;
  endfunction

`ifdef ROOM_BORDER_EN
  function automatic logic on_border(input logic [7:0] cx, input logic [6:0] cy);
    return (cx == 8'd0) || (cx == TW_LAST) || (cy == 7'd0) || (cy == TH_LAST);
  endfunction
`endif

  // Room origin from the latched index: column = room mod 5, row = room div 5.
  assign w_col = (r_room >= 4'd5) ? 3'(r_room - 4'd5) : r_room[2:0];
  assign w_ox  = {w_col, 5'b00000} + 8'd12;
  assign w_oy  = (r_room >= 4'd5) ? 7'd86 : 7'd26;

  always_comb begin
    w_state_nxt  = r_state;
    w_cx_nxt     = r_cx;
    w_cy_nxt     = r_cy;
    w_room_nxt   = r_room;
    w_funct_nxt  = r_funct;
    w_onoff_nxt  = r_onoff;
    w_x_nxt      = r_x;
    w_y_nxt      = r_y;
    w_colour_nxt = r_colour;
    w_plot_nxt   = 1'b0;
    w_done_nxt   = 1'b0;

    case (r_state)
      IDLE: begin
        // Clear has priority over a simultaneous draw request.
        if (bus.clearinitsignal) begin
          w_state_nxt = CLEAR;
          w_cx_nxt    = 8'd0;
          w_cy_nxt    = 7'd0;
        end else if (bus.drawen) begin
          if (bus.roomno <= 4'd9) begin
            w_state_nxt = DRAW;
            w_room_nxt  = bus.roomno;
            w_funct_nxt = bus.funct;
            w_onoff_nxt = bus.onoff;
            w_cx_nxt    = 8'd0;
            w_cy_nxt    = 7'd0;
          end else begin
            w_state_nxt = DONE;
          end
        end
      end

      DRAW: begin
        w_x_nxt    = w_ox + r_cx;
        w_y_nxt    = w_oy + r_cy;
        w_plot_nxt = 1'b1;
`ifdef ROOM_BORDER_EN
        w_colour_nxt = on_border(r_cx, r_cy) ? 3'b111 : fill_colour(r_funct, r_onoff);
`else
        w_colour_nxt = fill_colour(r_funct, r_onoff);
`endif
        if (r_cx == TW_LAST) begin
          w_cx_nxt = 8'd0;
          if (r_cy == TH_LAST) begin
            w_cy_nxt    = 7'd0;
            w_state_nxt = DONE;
          end else begin
            w_cy_nxt = r_cy + 7'd1;
          end
        end else begin
          w_cx_nxt = r_cx + 8'd1;
        end
      end

      CLEAR: begin
        w_x_nxt      = r_cx;
        w_y_nxt      = r_cy;
        w_colour_nxt = 3'b000;
        w_plot_nxt   = 1'b1;
        if (r_cx == SW_LAST) begin
          w_cx_nxt = 8'd0;
          if (r_cy == SH_LAST) begin
            w_cy_nxt    = 7'd0;
            w_state_nxt = DONE;
          end else begin
            w_cy_nxt = r_cy + 7'd1;
          end
        end else begin
          w_cx_nxt = r_cx + 8'd1;
        end
      end

      DONE: begin
        // The pulse lands the cycle after the last pixel, with plot low.
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cx     <= 8'd0;
      r_cy     <= 7'd0;
      r_room   <= 4'd0;
      r_funct  <= 1'b0;
      r_onoff  <= 1'b0;
      r_x      <= 8'd0;
      r_y      <= 7'd0;
      r_colour <= 3'd0;
      r_plot   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cx     <= w_cx_nxt;
      r_cy     <= w_cy_nxt;
      r_room   <= w_room_nxt;
      r_funct  <= w_funct_nxt;
      r_onoff  <= w_onoff_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_colour <= w_colour_nxt;
      r_plot   <= w_plot_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign bus.x         = r_x;
  assign bus.y         = r_y;
  assign bus.colour    = r_colour;
  assign bus.plot      = r_plot;
  assign bus.countDone = r_done;
  assign bus.busy      = (r_state != IDLE);

endmodule

// File: tb/tb_room_tile_drawer.sv
// tb_room_tile_drawer
// Table-driven bench for room_tile_drawer: each record starts one operation
// and lists the hand-computed origin, size, fill colour, plot count and
// start-to-countDone latency. Reset behaviour is covered by hand sequences.
module tb_room_tile_drawer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  room_tile_drawer_if bif ();

  room_tile_drawer #(
    .TILE_W(8), .TILE_H(8), .SCREEN_W(160), .SCREEN_H(120)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bif)
  );

  typedef struct {
    logic [3:0] rn;
    logic       f;
    logic       o;
    logic       clr;
    int         repulse;   // cycle at which a stray drawen is pulsed (0 = none)
    int         ox;
    int         oy;
    int         w;
    int         h;
    logic [2:0] fill;
    int         plots;
    int         lat;
  } vec_t;

  vec_t tbl[7];

  int n_vec = 0;
  int n_err = 0;

  // Per-operation observations.
  int plots, lat, fx, fy, lx, ly, colerr, rasterr, white, pdone, dwide, extra, busy0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic run_op(input vec_t v);
    int budget;
    int cxm, cym;
    logic brd;
    logic [2:0] ec;
    budget = v.lat + 50;
    plots = 0; lat = -1; fx = -1; fy = -1; lx = -1; ly = -1;
    colerr = 0; rasterr = 0; white = 0; pdone = -1; dwide = -1; extra = 0;
    bif.roomno = v.rn;
    bif.funct = v.f;
    bif.onoff = v.o;
    bif.drawen = 1'b1;
    bif.clearinitsignal = v.clr;
    @(posedge clk);
    @(negedge clk);
    bif.drawen = 1'b0;
    bif.clearinitsignal = 1'b0;
    busy0 = int'(bif.busy);
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (bif.plot) begin
        cxm = plots % v.w;
        cym = plots / v.w;
        if (int'(bif.x) != v.ox + cxm || int'(bif.y) != v.oy + cym) rasterr++;
        brd = !v.clr && (cxm == 0 || cxm == v.w - 1 || cym == 0 || cym == v.h - 1);
`ifdef ROOM_BORDER_EN
        ec = brd ? 3'b111 : v.fill;
`else
        ec = v.fill;
`endif
        if (bif.colour != ec) colerr++;
        if (bif.colour == 3'b111) white++;
        if (plots == 0) begin fx = int'(bif.x); fy = int'(bif.y); end
        lx = int'(bif.x);
        ly = int'(bif.y);
        plots++;
      end
      if (bif.countDone) begin
        lat = cyc;
        pdone = int'(bif.plot);
        break;
      end
      if (v.repulse != 0 && cyc == v.repulse) begin
        bif.roomno = 4'd0; bif.funct = 1'b1; bif.onoff = 1'b1;
        bif.drawen = 1'b1;
      end else begin
        bif.drawen = 1'b0;
      end
    end
    bif.drawen = 1'b0;
    @(posedge clk);
    @(negedge clk);
    dwide = int'(bif.countDone);
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bif.countDone || bif.plot) extra++;
    end
  endtask

  initial begin
    int exp_white;
    int cnt;
    bif.drawen = 1'b0;
    bif.clearinitsignal = 1'b0;
    bif.roomno = 4'd0;
    bif.funct = 1'b0;
    bif.onoff = 1'b0;

    //            rn     f     o     clr   rp  ox   oy  w    h    fill    plots  lat
    tbl[0] = '{4'd0,  1'b1, 1'b1, 1'b0, 0,  12,  26, 8,   8,   3'b110, 64,    65};
    tbl[1] = '{4'd7,  1'b0, 1'b0, 1'b0, 0,  76,  86, 8,   8,   3'b100, 64,    65};
    tbl[2] = '{4'd3,  1'b0, 1'b1, 1'b0, 20, 108, 26, 8,   8,   3'b010, 64,    65};
    tbl[3] = '{4'd9,  1'b1, 1'b0, 1'b0, 0,  140, 86, 8,   8,   3'b001, 64,    65};
    tbl[4] = '{4'd12, 1'b1, 1'b1, 1'b0, 0,  0,   0,  8,   8,   3'b000, 0,     1};
    tbl[5] = '{4'd15, 1'b0, 1'b0, 1'b0, 0,  0,   0,  8,   8,   3'b000, 0,     1};
    tbl[6] = '{4'd5,  1'b1, 1'b1, 1'b1, 0,  0,   0,  160, 120, 3'b000, 19200, 19201};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_x", int'(bif.x), 0);
    chk("reset_y", int'(bif.y), 0);
    chk("reset_colour", int'(bif.colour), 0);
    chk("reset_plot", int'(bif.plot), 0);
    chk("reset_busy", int'(bif.busy), 0);
    chk("reset_countDone", int'(bif.countDone), 0);

    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i]);
`ifdef ROOM_BORDER_EN
      exp_white = (!tbl[i].clr && tbl[i].plots > 0) ? 2 * tbl[i].w + 2 * tbl[i].h - 4 : 0;
`else
      exp_white = 0;
`endif
      chk($sformatf("v%0d_busy", i), busy0, 1);
      chk($sformatf("v%0d_plots", i), plots, tbl[i].plots);
      chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("v%0d_plot_at_done", i), pdone, 0);
      chk($sformatf("v%0d_done_width", i), dwide, 0);
      chk($sformatf("v%0d_raster_errs", i), rasterr, 0);
      chk($sformatf("v%0d_colour_errs", i), colerr, 0);
      chk($sformatf("v%0d_white", i), white, exp_white);
      chk($sformatf("v%0d_extra_activity", i), extra, 0);
      if (tbl[i].plots > 0) begin
        chk($sformatf("v%0d_first_x", i), fx, tbl[i].ox);
        chk($sformatf("v%0d_first_y", i), fy, tbl[i].oy);
        chk($sformatf("v%0d_last_x", i), lx, tbl[i].ox + tbl[i].w - 1);
        chk($sformatf("v%0d_last_y", i), ly, tbl[i].oy + tbl[i].h - 1);
      end
    end

    // Reset at pixel 20 of a room 1 draw aborts without countDone.
    bif.roomno = 4'd1; bif.funct = 1'b1; bif.onoff = 1'b1;
    bif.drawen = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bif.drawen = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40 && cnt < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bif.plot) cnt++;
    end
    chk("abort_reach_pixel20", cnt, 20);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_plot", int'(bif.plot), 0);
    chk("abort_countDone", int'(bif.countDone), 0);
    chk("abort_busy", int'(bif.busy), 0);
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bif.countDone || bif.plot) cnt++;
    end
    chk("abort_no_activity", cnt, 0);

    // A fresh draw after the abort completes normally (room 1 -> origin 44,26).
    run_op('{4'd1, 1'b1, 1'b1, 1'b0, 0, 44, 26, 8, 8, 3'b110, 64, 65});
    chk("post_abort_plots", plots, 64);
    chk("post_abort_latency", lat, 65);
    chk("post_abort_raster_errs", rasterr, 0);
    chk("post_abort_colour_errs", colerr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
